// File: rtl/aes_pkg.sv
// aes_pkg: shared types, constants and GF(2^8) helpers for the iterative
// AES-128 encryption controller (aes_enc_ctrl) and its sub-modules.
//   aes_st_e     : controller FSM states
//   AES_NR       : number of rounds (AES-128 only)
//   AES_BLK_W    : block width in bits
//   xtime        : multiply by x in GF(2^8), polynomial 0x11B
//   shift_rows   : ShiftRows on a 128-bit column-major state (byte 0 = [127:120])
//   mix_column32 : MixColumns on one 32-bit column (row 0 = [31:24])
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_BLK_W = 128;

  typedef enum logic [1:0] {
    AES_IDLE = 2'd0,
    AES_SUB  = 2'd1,
    AES_MIX  = 2'd2,
    AES_DONE = 2'd3
  } aes_st_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte (row r, column c) sits at index 4*c + r, counted from the MSB.
  function automatic logic [AES_BLK_W-1:0] shift_rows(input logic [AES_BLK_W-1:0] s);
    logic [AES_BLK_W-1:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[AES_BLK_W-1-8*(4*c+r) -: 8] = s[AES_BLK_W-1-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_column32(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/mix_columns.sv
// mix_columns: combinational MixColumns over all four columns of the state.
//   i_st : 128-bit state, column-major, byte 0 = [127:120]
//   o_st : MixColumns(i_st)
module mix_columns
  import aes_pkg::*;
(
  input  logic [AES_BLK_W-1:0] i_st,
  output logic [AES_BLK_W-1:0] o_st
);

  always_comb begin
    o_st = '0;
    for (int c = 0; c < 4; c++) begin
      o_st[AES_BLK_W-1-32*c -: 32] = mix_column32(i_st[AES_BLK_W-1-32*c -: 32]);
    end
  end

endmodule

// File: rtl/subbytes.sv
// subbytes: registered SubBytes over a 128-bit state, one cycle of latency.
//   clk  : rising-edge clock
//   i_st : state to substitute
//   o_sb : SubBytes(i_st) from the previous cycle
// The output register has no reset; its contents are only consumed one
// cycle after a valid state was presented.
module subbytes
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic [AES_BLK_W-1:0] i_st,
  output logic [AES_BLK_W-1:0] o_sb
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = a;
    e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic [AES_BLK_W-1:0] w_sb_p0;
  logic [AES_BLK_W-1:0] r_sb_p1;

  always_comb begin
    w_sb_p0 = '0;
    for (int i = 0; i < 16; i++) begin
      w_sb_p0[AES_BLK_W-1-8*i -: 8] = sbox(i_st[AES_BLK_W-1-8*i -: 8]);
    end
  end

  // stage p0 -> p1
  always_ff @(posedge clk) begin
    r_sb_p1 <= w_sb_p0;
  end

  assign o_sb = r_sb_p1;

endmodule

// File: rtl/aes_enc_ctrl.sv
// aes_enc_ctrl: iterative AES-128 encryption round controller.
// Accepts one plaintext block (in_valid/in_ready), runs NR rounds through a
// single shared registered subbytes instance (two cycles per round: SUB, MIX),
// then presents the ciphertext (out_valid/out_ready) until it is taken.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : plaintext handshake, data_in = plaintext
//   rk_idx/rk_data     : round-key address out, round key back (combinational)
//   out_valid/out_ready: ciphertext handshake, data_out = registered ciphertext
//   busy               : high while rounds are running (SUB or MIX)
//   abort              : only when AES_ENC_CTRL_ABORT_EN is defined; returns
//                        to IDLE from SUB/MIX/DONE on the next edge
module aes_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] data_in,
  output logic [3:0]           rk_idx,
  input  logic [AES_BLK_W-1:0] rk_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AES_BLK_W-1:0] data_out,
  output logic                 busy
`ifdef AES_ENC_CTRL_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam logic [3:0] LP_NR = 4'(NR);

  aes_st_e              r_state, w_state_nxt;
  logic [AES_BLK_W-1:0] r_st, w_st_nxt;
  logic [3:0]           r_rnd, w_rnd_nxt;
  logic [AES_BLK_W-1:0] r_data_out, w_data_out_nxt;
  logic [AES_BLK_W-1:0] w_sb;
  logic [AES_BLK_W-1:0] w_sr;
  logic [AES_BLK_W-1:0] w_mc;
  logic                 w_abort;

`ifdef AES_ENC_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  subbytes u_subbytes (
    .clk  (clk),
    .i_st (r_st),
    .o_sb (w_sb)
  );

  assign w_sr = shift_rows(w_sb);

  mix_columns u_mix_columns (
    .i_st (w_sr),
    .o_st (w_mc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= AES_IDLE;
      r_st       <= '0;
      r_rnd      <= 4'd0;
      r_data_out <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_st       <= w_st_nxt;
      r_rnd      <= w_rnd_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_st_nxt       = r_st;
    w_rnd_nxt      = r_rnd;
    w_data_out_nxt = r_data_out;
    rk_idx         = 4'd0;
    case (r_state)
      AES_IDLE: begin
        if (in_valid) begin
          w_st_nxt    = data_in ^ rk_data;
          w_rnd_nxt   = 4'd1;
          w_state_nxt = AES_SUB;
        end
      end
      AES_SUB: begin
        rk_idx = r_rnd;
        // subbytes captures SubBytes(r_st) at the end of this cycle.
        w_state_nxt = w_abort ? AES_IDLE : AES_MIX;
      end
      AES_MIX: begin
        rk_idx = r_rnd;
        // An abort drops the round result so data_out keeps its old value.
        if (w_abort) begin
          w_state_nxt = AES_IDLE;
        end else if (r_rnd == LP_NR) begin
          w_st_nxt       = w_sr ^ rk_data;
          w_data_out_nxt = w_sr ^ rk_data;
          w_state_nxt    = AES_DONE;
        end else begin
          w_st_nxt    = w_mc ^ rk_data;
          w_rnd_nxt   = r_rnd + 4'd1;
          w_state_nxt = AES_SUB;
        end
      end
      AES_DONE: begin
        if (out_ready || w_abort) w_state_nxt = AES_IDLE;
      end
      default: w_state_nxt = AES_IDLE;
    endcase
  end

  assign in_ready  = (r_state == AES_IDLE);
  assign out_valid = (r_state == AES_DONE);
  assign busy      = (r_state == AES_SUB) || (r_state == AES_MIX);
  assign data_out  = r_data_out;

endmodule

// File: doc/aes_enc_ctrl.md
# aes_enc_ctrl

Iterative AES-128 encryption round controller. It accepts one 128-bit plaintext block through a valid/ready handshake and runs 10 rounds through one time-shared `subbytes` instance. It then presents the ciphertext through a second valid/ready handshake. Round keys come from an external key schedule, addressed by round index. The block sits between the host/bus front end and the key-expansion store.

## Interface
- `NR`, 10: number of rounds. Only 10 (AES-128) is supported.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: plaintext offered.
- `in_ready` output 1: controller can accept a block.
- `data_in` input 128: plaintext. Byte 0 is `[127:120]`; column-major state order per FIPS-197.
- `rk_idx` output 4: round-key index, 0..10.
- `rk_data` input 128: round key `rk_idx`. Must be combinationally valid in the same cycle.
- `out_valid` output 1: ciphertext available.
- `out_ready` input 1: consumer accepts ciphertext.
- `data_out` output 128: ciphertext. Registered.
- `busy` output 1: high in SUB or MIX.
- `abort` input 1: present only with `AES_ENC_CTRL_ABORT_EN`.

## Operation
- State register `st`, 128 bits. Round counter `rnd`, 4 bits. FSM states are IDLE, SUB, MIX and DONE.
- **IDLE**
  - `in_ready`=1 and `rk_idx`=0.
  - On `in_valid`: `st <= data_in ^ rk_data`, `rnd <= 1`, go to SUB.
- **SUB**
  - `subbytes` registers `SubBytes(st)` at the end of the cycle.
  - `rk_idx`=`rnd`. Go to MIX.
- **MIX**
  - `rk_idx`=`rnd`.
  - If `rnd`<10: `st <= MixColumns(ShiftRows(sb_out)) ^ rk_data`, `rnd <= rnd+1`, go to SUB.
  - If `rnd`==10: `st <= ShiftRows(sb_out) ^ rk_data` (MixColumns skipped), `data_out` loads the same value, go to DONE.
- **DONE**
  - `out_valid`=1 and `data_out` is held stable.
  - When `out_ready`=1: go to IDLE.
  - `in_ready`=0. There is no same-cycle bypass; the next block is accepted no earlier than the cycle after the output handshake.
- `in_valid` is ignored outside IDLE.
- `out_ready` is ignored outside DONE.
- `rnd` never exceeds 10. Values 11..15 are unreachable.
- GF(2^8) arithmetic uses `xtime` with reduction polynomial 0x11B. All XORs are 128-bit and carry-free.

## Timing
- Reset values (held while `rst`=1):
  - `st`=IDLE, so `in_ready`=1.
  - `out_valid`=0, `busy`=0, `rk_idx`=0, `data_out`=0, `rnd`=0, `st`=0.
- `rst` asserted mid-operation returns the block to IDLE immediately and discards the partial result. The `subbytes` pipeline register is not reset; its content is don't-care in IDLE.
- Latency: with input handshake at edge T, `out_valid` rises in cycle T+21. That is 1 load cycle plus 10×2 round cycles.
- Throughput: one block per 22 cycles when `out_ready` is tied high.
- `out_valid` stays high until the handshake. `data_out` must not change while `out_valid`=1.
- Round r result is in `st` during cycle T+1+2r.

## Configuration
- Macro `AES_ENC_CTRL_ABORT_EN`.
  - **Defined:** the `abort` input exists. `abort`=1 in SUB, MIX or DONE forces IDLE on the next edge.
    - `out_valid` drops in that cycle; `data_out` keeps its last value.
    - `abort` in IDLE has no effect. A simultaneous `in_valid` is still accepted.
    - `abort` in DONE together with `out_ready`: the transfer counts as complete; the result is IDLE either way.
  - **Undefined:** the port is absent, and behaviour is identical to abort tied 0.

## Structure
- Package `aes_pkg` holds:
  - FSM state enum `aes_st_e`.
  - `AES_NR`=10 and `AES_BLK_W`=128.
  - Functions `xtime`, `shift_rows` and `mix_column32`.
- Sub-modules:
  - Existing `subbytes` (registered, 1-cycle latency): the single shared instance.
  - New `mix_columns`: combinational 4×column MixColumns, instantiated once.

## Test plan
- **FIPS-197 C.1:** key 000102…0f (bench drives precomputed schedule), pt 00112233445566778899aabbccddeeff -> `data_out`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` rises exactly 21 cycles after the accept.
- **FIPS-197 App. B:** key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Check `rk_idx` sequence 0,1,1,2,2,…,10,10.
- **Backpressure:** hold `out_ready`=0 for 15 cycles in DONE -> `out_valid`=1 and `data_out` stable throughout; `in_ready`=0 and a held `in_valid` is not accepted until the cycle after the handshake.
- **Back-to-back:** `in_valid` and `out_ready` tied high with the C.1 and B vectors alternating -> correct ciphertexts at 22-cycle spacing.
- **Reset mid-round:** assert `rst` in cycle T+9 -> all outputs at reset values immediately; the next block after release encrypts correctly.
- **Abort (macro defined):** pulse `abort` in MIX of round 5 -> IDLE next cycle, `out_valid` never asserted; the following C.1 block yields the correct ciphertext.
